// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_pkg
// Purpose  : Shared definitions for the instruction-memory boot loader:
//            FSM state encoding, bytes per instruction word and the
//            big-endian byte-lane helper.
// Revision : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_DATA = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_e;

    localparam int BYTES_PER_WORD = 4;

    // Bit position of the least significant bit of byte lane 'lane' when
    // bytes arrive most-significant first (lane 0 -> [31:24]).
    function automatic logic [4:0] be_lane_lsb(input logic [1:0] lane);
        return 5'(8 * (BYTES_PER_WORD - 1 - int'(lane)));
    endfunction

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_if
// Purpose  : Byte-stream input handshake plus instruction-memory write port
//            of the boot loader.
//   byte_valid / byte_data / byte_ready : source -> loader byte stream
//   imem_we / imem_addr / imem_wdata    : loader -> instruction memory
//   master modport : the loader side
//   slave modport  : byte source / memory side
// Revision : 1.0 - initial release
// ============================================================================
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;

    modport master (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport slave (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );
endinterface : imem_loader_if
`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_byte_packer
// Purpose  : Packs accepted bytes big-endian into 32-bit words.
//   clk        : system clock
//   clr        : synchronous clear of lane count and partial word
//   accept     : a byte is transferred this cycle
//   byte_in    : transferred byte
//   word_valid : high on the accept of the 4th byte of a word
//   word       : complete word, valid while word_valid is high
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        clr,
    input  wire logic        accept,
    input  wire logic [7:0]  byte_in,
    output logic             word_valid,
    output logic [31:0]      word
);

    logic [1:0]  r_lane;
    logic [31:0] r_word;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_lane <= 2'd0;
            r_word <= 32'd0;
        end else if (accept) begin
            r_word[be_lane_lsb(r_lane) +: 8] <= byte_in;
            r_lane <= r_lane + 2'd1;
        end
    end

    // The last byte is merged combinationally so the FSM sees the whole
    // word on the same edge as the 4th handshake.
    assign word_valid = accept && (r_lane == 2'(BYTES_PER_WORD - 1));
    assign word       = {r_word[31:8], byte_in};

endmodule : imem_loader_byte_packer
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Boot-time instruction-memory writer. Receives a 4-byte
//            big-endian word count N followed by N big-endian words, writes
//            them to word addresses 0..N-1 and then releases the core.
//   clk       : system clock
//   rst       : synchronous active-low reset
//   start     : single-cycle pulse, begins a load (from IDLE/DONE/ERR)
//   bus       : byte stream in, instruction-memory write port out
//   cpu_rst_n : core reset, low while not loaded
//   done      : image loaded, core released
//   error     : load aborted (oversize header or timeout)
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  wire logic      clk,
    input  wire logic      rst,
    input  wire logic      start,
    imem_loader_if.master  bus,
    output logic           cpu_rst_n,
    output logic           done,
    output logic           error
);

    localparam int          TO_W        = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [32:0] c_capacity  = 33'(1) << ADDR_WIDTH;
    localparam logic [TO_W:0] c_to_limit = (TO_W + 1)'(TIMEOUT_CYCLES);

    state_e                r_state;
    state_e                w_state_nxt;

    logic                  w_busy;
    logic                  w_accept;
    logic                  w_word_valid;
    logic [31:0]           w_word;
    logic                  w_start_go;
    logic                  w_timeout;
    logic                  w_sched_write;
    logic                  w_pack_clr;

    logic [ADDR_WIDTH:0]   r_remaining;
    logic [ADDR_WIDTH-1:0] r_word_idx;
    logic [TO_W-1:0]       r_timeout;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic                  r_done;
    logic                  r_cpu_rst_n;
    logic                  r_error;

    assign w_busy     = (r_state == ST_HDR) || (r_state == ST_DATA);
    assign w_accept   = bus.byte_valid && w_busy;
    assign w_pack_clr = !rst || w_start_go || w_timeout;

    imem_loader_byte_packer u_packer (
        .clk        (clk),
        .clr        (w_pack_clr),
        .accept     (w_accept),
        .byte_in    (bus.byte_data),
        .word_valid (w_word_valid),
        .word       (w_word)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_start_go    = 1'b0;
        w_sched_write = 1'b0;
        // Fires on the idle cycle that brings the counter up to the limit.
        w_timeout     = (TIMEOUT_CYCLES != 0) && w_busy && !w_accept &&
                        (({1'b0, r_timeout} + (TO_W + 1)'(1)) == c_to_limit);
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    w_state_nxt = ST_HDR;
                    w_start_go  = 1'b1;
                end
            end
            ST_HDR: begin
                if (w_timeout) begin
                    w_state_nxt = ST_ERR;
                end else if (w_word_valid) begin
                    if (w_word == 32'd0) begin
                        w_state_nxt = ST_DONE;
                    end else if ({1'b0, w_word} > c_capacity) begin
                        w_state_nxt = ST_ERR;
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                // The final write is held visible for one cycle in DATA;
                // the move to DONE coincides with the strobe dropping.
                if (r_we && (r_remaining == '0)) begin
                    w_state_nxt = ST_DONE;
                end else if (w_timeout) begin
                    w_state_nxt = ST_ERR;
                end else if (w_word_valid && (r_remaining != '0)) begin
                    w_sched_write = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_remaining <= '0;
            r_word_idx  <= '0;
            r_timeout   <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= 32'd0;
            r_done      <= 1'b0;
            r_cpu_rst_n <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_we <= w_sched_write;
            if (w_sched_write) begin
                r_addr      <= r_word_idx;
                r_wdata     <= w_word;
                r_word_idx  <= r_word_idx + ADDR_WIDTH'(1);
                r_remaining <= r_remaining - (ADDR_WIDTH + 1)'(1);
            end
            if ((r_state == ST_HDR) && w_word_valid) begin
                r_remaining <= w_word[ADDR_WIDTH:0];
            end
            if (w_start_go) begin
                r_word_idx <= '0;
            end

            if (w_busy && !w_accept) begin
                r_timeout <= r_timeout + TO_W'(1);
            end else begin
                r_timeout <= '0;
            end

            r_done      <= (w_state_nxt == ST_DONE);
            r_cpu_rst_n <= (w_state_nxt == ST_DONE);
            r_error     <= (w_state_nxt == ST_ERR);
        end
    end

    assign bus.byte_ready = w_busy;
    assign bus.imem_we    = r_we;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;
    assign cpu_rst_n      = r_cpu_rst_n;
    assign done           = r_done;
    assign error          = r_error;

endmodule : imem_loader
`default_nettype wire
